// File: rtl/riscv_lsu.sv
// Word-only load/store unit for RV32I LW/SW: decodes, checks alignment, drives a
// valid/ready memory request, waits for load data with a timeout, then writes back.
module riscv_lsu #(
   parameter int XLEN        = 32,
   parameter int RSP_TIMEOUT = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            mem_we,
   output logic [2:0]      mem_size,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            err_valid,
   output logic [1:0]      err_code,
   output logic [XLEN-1:0] err_addr
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REQ      = 2'd1;
   localparam logic [1:0] WAIT_RSP = 2'd2;
   localparam logic [1:0] WB       = 2'd3;

   localparam int CW = $clog2(RSP_TIMEOUT + 1);

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [4:0]      rd;
   logic [XLEN-1:0] data;
   logic [2:0]      size;

   logic            is_lw;
   logic            is_sw;
   logic [11:0]     imm12;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] eff_addr;
   logic            unused_rs_fields;

   assign unused_rs_fields = ^instr[19:15];

   always_comb begin
      is_lw    = (instr[6:0] == 7'b0000011) && (instr[14:12] == 3'b010);
      is_sw    = (instr[6:0] == 7'b0100011) && (instr[14:12] == 3'b010);
      imm12    = is_sw ? {instr[31:25], instr[11:7]} : instr[31:20];
      imm      = {{(XLEN-12){imm12[11]}}, imm12};
      eff_addr = rs1_val + imm;
   end

   assign instr_ready   = (state == IDLE);
   assign mem_req_valid = (state == REQ);
   assign mem_size      = size;
   assign wb_valid      = (state == WB) && (rd != 5'd0);
   assign wb_rd         = rd;
   assign wb_data       = data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd        <= '0;
         data      <= '0;
         size      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         err_valid <= 1'b0;
         err_code  <= '0;
         err_addr  <= '0;
      end else begin
         err_valid <= 1'b0;
         size      <= 3'b010;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  if (!is_lw && !is_sw) begin
                     err_valid <= 1'b1;
                     err_code  <= 2'b10;
                     err_addr  <= '0;
                  end else if (eff_addr[1:0] != 2'b00) begin
                     err_valid <= 1'b1;
                     err_code  <= 2'b01;
                     err_addr  <= eff_addr;
                  end else begin
                     state     <= REQ;
                     mem_addr  <= eff_addr;
                     mem_wdata <= is_sw ? rs2_val : '0;
                     mem_we    <= is_sw;
                     rd        <= instr[11:7];
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state <= mem_we ? IDLE : WAIT_RSP;
                  cnt   <= '0;
               end
            end
            // A response arriving on the final counted cycle still takes priority.
            WAIT_RSP: begin
               if (mem_rsp_valid) begin
                  data  <= mem_rdata;
                  state <= WB;
               end else if (cnt == CW'(RSP_TIMEOUT - 1)) begin
                  err_valid <= 1'b1;
                  err_code  <= 2'b11;
                  err_addr  <= mem_addr;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, hand-built reset
// sequences and randomized transactions predicted by a transaction-level model.
module tb_riscv_lsu;

   localparam int TO = 32;

   localparam int K_LOAD  = 0;
   localparam int K_STORE = 1;
   localparam int K_MIS   = 2;
   localparam int K_ILL   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [2:0]  mem_size;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] rs1;
      logic [31:0] rs2;
      int          stall;
      int          delay;
      logic [31:0] rdata;
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } vec_t;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } pred_t;

   vec_t vecs[10];

   riscv_lsu #(.XLEN(32), .RSP_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .rs1_val       (rs1_val),
      .rs2_val       (rs2_val),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_size      (mem_size),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .err_valid     (err_valid),
      .err_code      (err_code),
      .err_addr      (err_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Writeback and error strobes must never coincide.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check_output("wb_err_exclusive", 32'(wb_valid & err_valid), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1r, input int imm);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12, rs1r, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_sw(input logic [4:0] rs2r, input logic [4:0] rs1r, input int imm);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12[11:5], rs2r, rs1r, 3'b010, i12[4:0], 7'b0100011};
   endfunction

   // Reference model: decode with plain arithmetic on the instruction word.
   function automatic pred_t predict(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
      pred_t p;
      int unsigned op;
      int unsigned f3;
      int          simm;
      op     = ins % 128;
      f3     = (ins / 4096) % 8;
      p.rd   = 5'((ins / 128) % 32);
      p.addr = 32'd0;
      p.wdata = 32'd0;
      if (op == 3 && f3 == 2) begin
         simm   = $signed(ins) >>> 20;
         p.kind = K_LOAD;
      end else if (op == 35 && f3 == 2) begin
         simm    = (($signed(ins) >>> 25) * 32) + int'((ins / 128) % 32);
         p.kind  = K_STORE;
         p.wdata = rs2;
      end else begin
         simm   = 0;
         p.kind = K_ILL;
      end
      if (p.kind != K_ILL) begin
         p.addr = rs1 + 32'(simm);
         if (p.addr % 4 != 0) begin
            p.kind = K_MIS;
         end
      end
      return p;
   endfunction

   task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int stall, input int delay, input logic [31:0] rdata,
                                 input int kind, input logic [31:0] eaddr, input logic [31:0] ewdata,
                                 input logic [4:0] erd, input int id);
      check_output($sformatf("t%0d ready_before", id), 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr       = ins;
      rs1_val     = rs1;
      rs2_val     = rs2;
      tick();
      instr_valid = 1'b0;
      instr       = $urandom;
      rs1_val     = $urandom;
      rs2_val     = $urandom;
      if (kind == K_ILL || kind == K_MIS) begin
         check_output($sformatf("t%0d err_valid", id), 32'(err_valid), 32'd1);
         check_output($sformatf("t%0d err_code", id), 32'(err_code), (kind == K_ILL) ? 32'd2 : 32'd1);
         check_output($sformatf("t%0d err_addr", id), err_addr, (kind == K_ILL) ? 32'd0 : eaddr);
         check_output($sformatf("t%0d no_req", id), 32'(mem_req_valid), 32'd0);
         check_output($sformatf("t%0d ready_err", id), 32'(instr_ready), 32'd1);
         tick();
         check_output($sformatf("t%0d err_one_cycle", id), 32'(err_valid), 32'd0);
         check_output($sformatf("t%0d no_req_after", id), 32'(mem_req_valid), 32'd0);
         return;
      end
      for (int i = 0; i <= stall; i++) begin
         check_output($sformatf("t%0d req_valid c%0d", id, i), 32'(mem_req_valid), 32'd1);
         check_output($sformatf("t%0d mem_addr c%0d", id, i), mem_addr, eaddr);
         check_output($sformatf("t%0d mem_wdata c%0d", id, i), mem_wdata, ewdata);
         check_output($sformatf("t%0d mem_we c%0d", id, i), 32'(mem_we), (kind == K_STORE) ? 32'd1 : 32'd0);
         check_output($sformatf("t%0d mem_size c%0d", id, i), 32'(mem_size), 32'd2);
         check_output($sformatf("t%0d busy c%0d", id, i), 32'(instr_ready), 32'd0);
         check_output($sformatf("t%0d quiet c%0d", id, i), 32'(wb_valid | err_valid), 32'd0);
         mem_req_ready = (i == stall);
         tick();
      end
      mem_req_ready = 1'b0;
      check_output($sformatf("t%0d req_drop", id), 32'(mem_req_valid), 32'd0);
      if (kind == K_STORE) begin
         check_output($sformatf("t%0d sw_idle", id), 32'(instr_ready), 32'd1);
         check_output($sformatf("t%0d sw_quiet", id), 32'(wb_valid | err_valid), 32'd0);
         return;
      end
      check_output($sformatf("t%0d lw_wait", id), 32'(instr_ready), 32'd0);
      for (int k = 0; k < TO; k++) begin
         if (k == delay) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = rdata;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            break;
         end
         tick();
      end
      if (delay < TO) begin
         check_output($sformatf("t%0d wb_valid", id), 32'(wb_valid), (erd != 5'd0) ? 32'd1 : 32'd0);
         check_output($sformatf("t%0d wb_rd", id), 32'(wb_rd), 32'(erd));
         check_output($sformatf("t%0d wb_data", id), wb_data, rdata);
         check_output($sformatf("t%0d wb_no_err", id), 32'(err_valid), 32'd0);
         check_output($sformatf("t%0d wb_busy", id), 32'(instr_ready), 32'd0);
         tick();
         check_output($sformatf("t%0d wb_one_cycle", id), 32'(wb_valid), 32'd0);
         check_output($sformatf("t%0d lw_idle", id), 32'(instr_ready), 32'd1);
      end else begin
         check_output($sformatf("t%0d to_err_valid", id), 32'(err_valid), 32'd1);
         check_output($sformatf("t%0d to_err_code", id), 32'(err_code), 32'd3);
         check_output($sformatf("t%0d to_err_addr", id), err_addr, eaddr);
         check_output($sformatf("t%0d to_idle", id), 32'(instr_ready), 32'd1);
         tick();
         check_output($sformatf("t%0d to_one_cycle", id), 32'(err_valid), 32'd0);
      end
   endtask

   initial begin
      pred_t p;
      logic [31:0] ins;
      logic [31:0] rs1;
      int          sel;
      int          dly;

      rst_n         = 1'b1;
      instr_valid   = 1'b0;
      instr         = 32'd0;
      rs1_val       = 32'd0;
      rs2_val       = 32'd0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'd0;
      #1 rst_n = 1'b0;

      vecs[0] = '{enc_lw(5'd5, 5'd1, 8), 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF,
                  K_LOAD, 32'h1008, 32'h0, 5'd5};
      vecs[1] = '{enc_sw(5'd2, 5'd3, -4), 32'h2000, 32'h55AA55AA, 3, 0, 32'h0,
                  K_STORE, 32'h1FFC, 32'h55AA55AA, 5'd0};
      vecs[2] = '{enc_lw(5'd4, 5'd1, 0), 32'h1001, 32'h0, 0, 0, 32'h0,
                  K_MIS, 32'h1001, 32'h0, 5'd0};
      vecs[3] = '{32'h00000013, 32'h1000, 32'h0, 0, 0, 32'h0,
                  K_ILL, 32'h0, 32'h0, 5'd0};
      vecs[4] = '{enc_lw(5'd7, 5'd2, 8), 32'hFFFFFFFC, 32'h0, 0, 2, 32'h12345678,
                  K_LOAD, 32'h00000004, 32'h0, 5'd7};
      vecs[5] = '{enc_lw(5'd9, 5'd2, 0), 32'h3000, 32'h0, 1, TO, 32'h0,
                  K_LOAD, 32'h3000, 32'h0, 5'd9};
      vecs[6] = '{enc_lw(5'd10, 5'd2, 4), 32'h3000, 32'h0, 0, TO - 1, 32'hCAFEF00D,
                  K_LOAD, 32'h3004, 32'h0, 5'd10};
      vecs[7] = '{enc_lw(5'd0, 5'd2, 0), 32'h40, 32'h0, 0, 1, 32'hA5A5A5A5,
                  K_LOAD, 32'h40, 32'h0, 5'd0};
      vecs[8] = '{32'h0020A0A3 & 32'hFFFF8FFF | 32'h00001000, 32'h100, 32'h0, 0, 0, 32'h0,
                  K_ILL, 32'h0, 32'h0, 5'd0};
      vecs[9] = '{enc_sw(5'd2, 5'd3, 2), 32'h100, 32'h77, 0, 0, 32'h0,
                  K_MIS, 32'h102, 32'h0, 5'd0};

      #12;
      check_output("rst instr_ready", 32'(instr_ready), 32'd1);
      check_output("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
      check_output("rst mem_addr", mem_addr, 32'd0);
      check_output("rst mem_wdata", mem_wdata, 32'd0);
      check_output("rst mem_we", 32'(mem_we), 32'd0);
      check_output("rst mem_size", 32'(mem_size), 32'd0);
      check_output("rst wb_valid", 32'(wb_valid), 32'd0);
      check_output("rst wb_data", wb_data, 32'd0);
      check_output("rst err_valid", 32'(err_valid), 32'd0);
      check_output("rst err_addr", err_addr, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 10; v++) begin
         apply_stimulus(vecs[v].ins, vecs[v].rs1, vecs[v].rs2, vecs[v].stall, vecs[v].delay,
                        vecs[v].rdata, vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].rd, v);
      end

      // Stray responses while idle must be ignored.
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'hBAD0BAD0;
      tick();
      tick();
      check_output("stray_rsp wb_valid", 32'(wb_valid), 32'd0);
      check_output("stray_rsp ready", 32'(instr_ready), 32'd1);
      mem_rsp_valid = 1'b0;

      // Reset during WAIT_RSP, then a late response.
      instr_valid = 1'b1;
      instr       = enc_lw(5'd6, 5'd1, 0);
      rs1_val     = 32'h5000;
      tick();
      instr_valid   = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      tick();
      check_output("midrst in_wait", 32'(instr_ready), 32'd0);
      rst_n = 1'b0;
      #2;
      check_output("midrst ready_async", 32'(instr_ready), 32'd1);
      check_output("midrst wb_data_clr", wb_data, 32'd0);
      rst_n         = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'h0BADF00D;
      tick();
      check_output("midrst late_rsp wb", 32'(wb_valid), 32'd0);
      check_output("midrst late_rsp err", 32'(err_valid), 32'd0);
      check_output("midrst ready", 32'(instr_ready), 32'd1);
      mem_rsp_valid = 1'b0;

      // Reset mid-REQ, then acceptance on the first edge after release.
      instr_valid = 1'b1;
      instr       = enc_sw(5'd4, 5'd1, 0);
      rs1_val     = 32'h6000;
      tick();
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      check_output("reqrst req_drop", 32'(mem_req_valid), 32'd0);
      rst_n = 1'b1;
      apply_stimulus(enc_sw(5'd4, 5'd1, 12), 32'h6000, 32'h13579BDF, 1, 0, 32'h0,
                     K_STORE, 32'h600C, 32'h13579BDF, 5'd0, 100);

      for (int r = 0; r < 40; r++) begin
         sel = $urandom_range(0, 9);
         rs1 = $urandom & 32'hFFFFFFFC;
         if (sel <= 3 || sel == 9) begin
            ins = enc_lw(5'($urandom), 5'($urandom), int'($urandom_range(0, 1023)) * 4 - 2048);
         end else if (sel <= 6) begin
            ins = enc_sw(5'($urandom), 5'($urandom), int'($urandom_range(0, 1023)) * 4 - 2048);
         end else if (sel == 7) begin
            ins = enc_lw(5'($urandom), 5'($urandom), int'($urandom_range(0, 1023)) * 4 - 2048);
            rs1 = rs1 + 32'($urandom_range(1, 3));
         end else begin
            ins = $urandom;
         end
         dly = (sel == 9) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
         rs2_val = $urandom;
         p = predict(ins, rs1, rs2_val);
         apply_stimulus(ins, rs1, rs2_val, int'($urandom_range(0, 3)), dly, $urandom,
                        p.kind, p.addr, p.wdata, p.rd, 200 + r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
